trigger_flow_ctrl: RTL and testbench
====================================

# trigger_flow_ctrl

Trigger admission controller in front of the event builder. It synchronises the external trigger and edge-detects it. It admits a trigger only when the builder can absorb another event: pending-event count below limit, output FIFO below threshold, and no dead time running. Each admitted trigger produces a clean fixed-width TRIGGER pulse for the event builder. The block keeps accepted and rejected trigger statistics and drives the module BUSY line.

## Interface
- MAX_PENDING, 15: maximum events triggered but not yet built; matches the 16-deep event/time counter FIFOs minus one.
- CLK  in  1  system clock, same clock as the event builder.
- RSTb  in  1  reset, asynchronous, active-low.
- ENABLE  in  1  trigger admission enable; 0 rejects every trigger.
- ALL_CLEAR  in  1  synchronous clear of counters and FSM.
- TRIG_IN  in  1  external trigger, asynchronous to CLK, level ≥3 CLK wide.
- EV_DONE  in  1  one-cycle pulse, event fully built (event builder DECREMENT_EVENT_COUNT).
- OUT_FIFO_CNT  in  12  event builder output FIFO usage (bit 11 = full).
- AF_THR  in  12  almost-full threshold; busy when OUT_FIFO_CNT ≥ AF_THR.
- PULSE_WIDTH  in  4  TRIG_OUT high time minus one, in CLK cycles.
- DEAD_TIME  in  8  CLK cycles of forced busy after the pulse ends.
- TRIG_OUT  out  1  trigger to event builder; reset 0.
- BUSY  out  1  registered busy flag; reset 1.
- PENDING  out  5  outstanding events; reset 0.
- ACCEPT_CNT  out  24  accepted triggers; reset 0; wraps.
- LOST_CNT  out  16  rejected trigger edges; reset 0; saturates at 16'hFFFF.

## Operation
- Synchroniser: s1<=TRIG_IN, s2<=s1, s3<=s2; edge = s2 & ~s3. Synchroniser flops reset to 0.
- block_cond = ~ENABLE | (PENDING ≥ MAX_PENDING) | (OUT_FIFO_CNT ≥ AF_THR) | (state ≠ IDLE).
- BUSY <= block_cond, registered every cycle.
- FSM states:
  - IDLE: on edge & ~block_cond, set TRIG_OUT<=1, load width counter with PULSE_WIDTH, ACCEPT_CNT+1, go to PULSE. On edge & block_cond, LOST_CNT+1 (saturating) and stay in IDLE.
  - PULSE: width counter decrements each cycle. When it reaches 0, set TRIG_OUT<=0. If DEAD_TIME = 0 go to IDLE; otherwise load the dead counter with DEAD_TIME and go to DEAD. Any edge seen in PULSE counts as lost.
  - DEAD: dead counter decrements; go to IDLE when it reaches 1. Any edge seen in DEAD counts as lost.
  - Illegal state encodings go to IDLE with TRIG_OUT=0.
- PENDING:
  - +1 on accept.
  - -1 on EV_DONE when PENDING > 0.
  - Accept and EV_DONE in the same cycle leave it unchanged.
  - EV_DONE with PENDING = 0 is ignored.
  - Accept is never possible at MAX_PENDING, so no overflow.
- ALL_CLEAR (priority over everything except reset): PENDING, ACCEPT_CNT and LOST_CNT go to 0, FSM goes to IDLE, TRIG_OUT goes to 0, synchroniser is untouched. A trigger edge in the ALL_CLEAR cycle is dropped and not counted.
- Reset during PULSE truncates TRIG_OUT immediately (asynchronous). BUSY is 1 while in reset.
- Threshold and width inputs are quasi-static; a change takes effect at the next accept.

## Timing
- TRIG_IN high first sampled at CLK edge k → s2=1 after k+1 → edge at k+2 → TRIG_OUT=1 after edge k+2.
- TRIG_OUT high for exactly PULSE_WIDTH+1 cycles.
- BUSY rises 1 cycle after an accept and stays high through PULSE and DEAD plus 1 cycle.
- Minimum accepted trigger spacing: PULSE_WIDTH+1+DEAD_TIME+1 cycles.
- PENDING and counters update on the same edge that sets TRIG_OUT.
- An EV_DONE pulse affects block_cond in the following cycle.

## Configuration
- LOST_TRIGGER_CNT_EN defined: LOST_CNT is implemented as above.
- LOST_TRIGGER_CNT_EN undefined: the counter logic is removed and LOST_CNT is tied to 16'h0000. All other behaviour is unchanged.

## Test plan
- Basic accept: PULSE_WIDTH=2, DEAD_TIME=0, single TRIG_IN rise → TRIG_OUT high 3 cycles, starting 3 edges after the first sample; ACCEPT_CNT=1, PENDING=1.
- Dead time: DEAD_TIME=10, second TRIG_IN rise 6 cycles after the first TRIG_OUT → not forwarded, LOST_CNT=1. A third rise after 20 cycles is accepted, ACCEPT_CNT=2.
- Pending limit: 15 spaced triggers with no EV_DONE → PENDING=15, BUSY=1, 16th trigger lost. One EV_DONE → PENDING=14, BUSY drops and the next trigger is accepted.
- FIFO threshold: AF_THR=1800, OUT_FIFO_CNT=1800 → trigger lost and BUSY=1. At OUT_FIFO_CNT=1799 → accepted.
- Simultaneous events: accept and EV_DONE in the same cycle with PENDING=3 → PENDING stays 3. EV_DONE with PENDING=0 → stays 0.
- ALL_CLEAR mid-pulse with PULSE_WIDTH=7 → TRIG_OUT=0 next cycle, FSM in IDLE, all counters 0. With LOST_TRIGGER_CNT_EN undefined, LOST_CNT stays 0 throughout.

Source files
------------

// File: rtl/trigger_flow_ctrl.sv
// trigger_flow_ctrl: trigger admission, pulse shaping and busy generation.
// Define LOST_TRIGGER_CNT_EN to build the lost-trigger counter.
module trigger_flow_ctrl #(
  parameter int MAX_PENDING = 15
) (
  input  logic        CLK,
  input  logic        RSTb,
  input  logic        ENABLE,
  input  logic        ALL_CLEAR,
  input  logic        TRIG_IN,
  input  logic        EV_DONE,
  input  logic [11:0] OUT_FIFO_CNT,
  input  logic [11:0] AF_THR,
  input  logic [3:0]  PULSE_WIDTH,
  input  logic [7:0]  DEAD_TIME,
  output logic        TRIG_OUT,
  output logic        BUSY,
  output logic [4:0]  PENDING,
  output logic [23:0] ACCEPT_CNT,
  output logic [15:0] LOST_CNT
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PULSE = 2'b01,
    S_DEAD  = 2'b10
  } state_t;

  state_t      r_state;
  logic        r_s1;
  logic        r_s2;
  logic        r_s3;
  logic [3:0]  r_wcnt;
  logic [7:0]  r_dcnt;
  logic        r_trig;
  logic        r_busy;
  logic [4:0]  r_pend;
  logic [23:0] r_acc;

  logic        w_edge;
  logic        w_block;
  logic        w_accept;
  logic        w_dec;

  assign w_edge   = r_s2 & ~r_s3;
  assign w_block  = ~ENABLE
                  | (r_pend >= 5'(MAX_PENDING))
                  | (OUT_FIFO_CNT >= AF_THR)
                  | (r_state != S_IDLE);
  assign w_accept = w_edge & ~w_block & ~ALL_CLEAR;
  assign w_dec    = EV_DONE & (r_pend != 5'd0);

  assign TRIG_OUT   = r_trig;
  assign BUSY       = r_busy;
  assign PENDING    = r_pend;
  assign ACCEPT_CNT = r_acc;

  // Three-flop synchroniser; the third flop gives the rising edge.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= TRIG_IN;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Admission FSM: pulse generation followed by optional dead time.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      r_state <= S_IDLE;
      r_trig  <= 1'b0;
      r_wcnt  <= 4'd0;
      r_dcnt  <= 8'd0;
    end else if (ALL_CLEAR) begin
      r_state <= S_IDLE;
      r_trig  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_trig  <= 1'b1;
            r_wcnt  <= PULSE_WIDTH;
            r_state <= S_PULSE;
          end
        end
        S_PULSE: begin
          if (r_wcnt == 4'd0) begin
            r_trig <= 1'b0;
            if (DEAD_TIME == 8'd0) begin
              r_state <= S_IDLE;
            end else begin
              r_dcnt  <= DEAD_TIME;
              r_state <= S_DEAD;
            end
          end else begin
            r_wcnt <= r_wcnt - 4'd1;
          end
        end
        S_DEAD: begin
          if (r_dcnt <= 8'd1) begin
            r_state <= S_IDLE;
          end else begin
            r_dcnt <= r_dcnt - 8'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_trig  <= 1'b0;
        end
      endcase
    end
  end

  // Busy is the registered block condition; held high in reset.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      r_busy <= 1'b1;
    end else begin
      r_busy <= w_block;
    end
  end

  // Outstanding event count; accept and done together cancel.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      r_pend <= 5'd0;
    end else if (ALL_CLEAR) begin
      r_pend <= 5'd0;
    end else if (w_accept && !w_dec) begin
      r_pend <= r_pend + 5'd1;
    end else if (w_dec && !w_accept) begin
      r_pend <= r_pend - 5'd1;
    end
  end

  // Accepted trigger counter, wraps.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      r_acc <= 24'd0;
    end else if (ALL_CLEAR) begin
      r_acc <= 24'd0;
    end else if (w_accept) begin
      r_acc <= r_acc + 24'd1;
    end
  end

`ifdef LOST_TRIGGER_CNT_EN
  logic [15:0] r_lost;
  logic        w_lost;

  assign w_lost   = w_edge & w_block & ~ALL_CLEAR;
  assign LOST_CNT = r_lost;

  // Rejected edge counter, saturating.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      r_lost <= 16'd0;
    end else if (ALL_CLEAR) begin
      r_lost <= 16'd0;
    end else if (w_lost && (r_lost != 16'hFFFF)) begin
      r_lost <= r_lost + 16'd1;
    end
  end
`else
  assign LOST_CNT = 16'h0000;
`endif

endmodule

// File: tb/tb_trigger_flow_ctrl.sv
// tb_trigger_flow_ctrl: directed checks of trigger_flow_ctrl.
// Expected lost counts follow LOST_TRIGGER_CNT_EN.
module tb_trigger_flow_ctrl;

`ifdef LOST_TRIGGER_CNT_EN
  localparam bit LOST_EN = 1'b1;
`else
  localparam bit LOST_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RSTb;
  logic        ENABLE;
  logic        ALL_CLEAR;
  logic        TRIG_IN;
  logic        EV_DONE;
  logic [11:0] OUT_FIFO_CNT;
  logic [11:0] AF_THR;
  logic [3:0]  PULSE_WIDTH;
  logic [7:0]  DEAD_TIME;
  logic        TRIG_OUT;
  logic        BUSY;
  logic [4:0]  PENDING;
  logic [23:0] ACCEPT_CNT;
  logic [15:0] LOST_CNT;

  int n_vec = 0;
  int n_err = 0;
  int exp_lost = 0;

  trigger_flow_ctrl dut (
    .CLK(CLK),
    .RSTb(RSTb),
    .ENABLE(ENABLE),
    .ALL_CLEAR(ALL_CLEAR),
    .TRIG_IN(TRIG_IN),
    .EV_DONE(EV_DONE),
    .OUT_FIFO_CNT(OUT_FIFO_CNT),
    .AF_THR(AF_THR),
    .PULSE_WIDTH(PULSE_WIDTH),
    .DEAD_TIME(DEAD_TIME),
    .TRIG_OUT(TRIG_OUT),
    .BUSY(BUSY),
    .PENDING(PENDING),
    .ACCEPT_CNT(ACCEPT_CNT),
    .LOST_CNT(LOST_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Rising edge held 3 cycles, then low 3 cycles; accept is on tick 3.
  task automatic fire();
    TRIG_IN = 1'b1;
    repeat (3) tick();
    TRIG_IN = 1'b0;
    repeat (3) tick();
  endtask

  task automatic done_pulse();
    EV_DONE = 1'b1;
    tick();
    EV_DONE = 1'b0;
  endtask

  task automatic lost_inc();
    if (LOST_EN) exp_lost++;
  endtask

  initial begin
    RSTb = 1'b0;
    ENABLE = 1'b1;
    ALL_CLEAR = 1'b0;
    TRIG_IN = 1'b0;
    EV_DONE = 1'b0;
    OUT_FIFO_CNT = 12'd0;
    AF_THR = 12'd1800;
    PULSE_WIDTH = 4'd2;
    DEAD_TIME = 8'd0;
    repeat (2) tick();
    chk("rst_trig", TRIG_OUT, 0);
    chk("rst_busy", BUSY, 1);
    chk("rst_pend", PENDING, 0);
    chk("rst_acc", ACCEPT_CNT, 0);
    chk("rst_lost", LOST_CNT, 0);
    RSTb = 1'b1;
    tick();
    chk("idle_busy", BUSY, 0);

    // basic accept, PW=2
    TRIG_IN = 1'b1;
    tick();
    chk("b_t1", TRIG_OUT, 0);
    tick();
    chk("b_t2", TRIG_OUT, 0);
    tick();
    chk("b_t3", TRIG_OUT, 1);
    chk("b_acc", ACCEPT_CNT, 1);
    chk("b_pend", PENDING, 1);
    tick();
    chk("b_t4", TRIG_OUT, 1);
    chk("b_busy", BUSY, 1);
    TRIG_IN = 1'b0;
    tick();
    chk("b_t5", TRIG_OUT, 1);
    tick();
    chk("b_t6", TRIG_OUT, 0);
    chk("b_busy6", BUSY, 1);
    tick();
    chk("b_busy7", BUSY, 0);

    // dead time 10, second rise lands in dead time
    DEAD_TIME = 8'd10;
    TRIG_IN = 1'b1;
    repeat (3) tick();
    chk("d_t3", TRIG_OUT, 1);
    chk("d_acc", ACCEPT_CNT, 2);
    TRIG_IN = 1'b0;
    repeat (6) tick();
    chk("d_t9", TRIG_OUT, 0);
    TRIG_IN = 1'b1;
    repeat (3) tick();
    lost_inc();
    chk("d_lost", LOST_CNT, exp_lost);
    chk("d_acc2", ACCEPT_CNT, 2);
    chk("d_trig", TRIG_OUT, 0);
    TRIG_IN = 1'b0;
    repeat (20) tick();
    TRIG_IN = 1'b1;
    repeat (3) tick();
    chk("d_t3b", TRIG_OUT, 1);
    chk("d_acc3", ACCEPT_CNT, 3);
    chk("d_pend3", PENDING, 3);
    TRIG_IN = 1'b0;
    repeat (15) tick();
    DEAD_TIME = 8'd0;

    // accept and done together at PENDING=3
    TRIG_IN = 1'b1;
    repeat (2) tick();
    EV_DONE = 1'b1;
    tick();
    EV_DONE = 1'b0;
    chk("s_pend", PENDING, 3);
    chk("s_acc", ACCEPT_CNT, 4);
    chk("s_trig", TRIG_OUT, 1);
    TRIG_IN = 1'b0;
    repeat (3) tick();
    repeat (3) done_pulse();
    chk("s_pend0", PENDING, 0);
    done_pulse();
    chk("s_pend00", PENDING, 0);

    // pending limit
    for (int i = 0; i < 15; i++) fire();
    chk("p_pend15", PENDING, 15);
    chk("p_acc", ACCEPT_CNT, 19);
    chk("p_busy", BUSY, 1);
    fire();
    lost_inc();
    chk("p_lost", LOST_CNT, exp_lost);
    chk("p_acc16", ACCEPT_CNT, 19);
    chk("p_pend16", PENDING, 15);
    done_pulse();
    chk("p_pend14", PENDING, 14);
    tick();
    chk("p_busy0", BUSY, 0);
    fire();
    chk("p_acc20", ACCEPT_CNT, 20);
    chk("p_pendb", PENDING, 15);
    for (int i = 0; i < 15; i++) done_pulse();
    chk("p_drain", PENDING, 0);

    // FIFO threshold
    OUT_FIFO_CNT = 12'd1800;
    repeat (2) tick();
    chk("f_busy", BUSY, 1);
    fire();
    lost_inc();
    chk("f_lost", LOST_CNT, exp_lost);
    chk("f_acc", ACCEPT_CNT, 20);
    OUT_FIFO_CNT = 12'd1799;
    repeat (2) tick();
    chk("f_busy0", BUSY, 0);
    fire();
    chk("f_acc2", ACCEPT_CNT, 21);
    chk("f_pend", PENDING, 1);

    // ALL_CLEAR mid-pulse, PW=7
    PULSE_WIDTH = 4'd7;
    TRIG_IN = 1'b1;
    repeat (3) tick();
    chk("c_trig", TRIG_OUT, 1);
    chk("c_acc", ACCEPT_CNT, 22);
    TRIG_IN = 1'b0;
    repeat (2) tick();
    chk("c_mid", TRIG_OUT, 1);
    ALL_CLEAR = 1'b1;
    tick();
    ALL_CLEAR = 1'b0;
    exp_lost = 0;
    chk("c_trig0", TRIG_OUT, 0);
    chk("c_pend", PENDING, 0);
    chk("c_acc0", ACCEPT_CNT, 0);
    chk("c_lost", LOST_CNT, 0);
    tick();
    chk("c_idle", BUSY, 0);
    fire();
    chk("c_acc1", ACCEPT_CNT, 1);
    repeat (4) tick();
    chk("c_w8", TRIG_OUT, 1);
    tick();
    chk("c_w9", TRIG_OUT, 0);
    tick();

    // admission disabled
    ENABLE = 1'b0;
    tick();
    fire();
    lost_inc();
    chk("e_acc", ACCEPT_CNT, 1);
    chk("e_lost", LOST_CNT, exp_lost);
    chk("e_busy", BUSY, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
